// File: rtl/spi_burst_host.sv
// SPI host for the 68k bus: TX/RX byte FIFOs, SPI modes 0-3, LSB-first, card-detect debounce, INT2_n.
// Define SPI_CRC16_EN to add a CRC16-CCITT register at address 10 (MODE[3] selects MISO or MOSI feed).
module spi_burst_host #(
   parameter int NUM_CS      = 2,
   parameter int FIFO_DEPTH  = 16,
   parameter int CD_DEBOUNCE = 1000000
) (
   input  logic              C100M,
   input  logic              RESET,
   input  logic [23:1]       ADDR,
   input  logic              access,
   input  logic              RW,
   input  logic              ds_n,
   output logic              dtack_n,
   input  logic [15:0]       data_in,
   output logic [15:0]       data_out,
   output logic              data_oe,
   output logic              INT2_n,
   output logic [NUM_CS-1:0] SS_n,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   input  logic              CD_n
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(CD_DEBOUNCE + 1);
   localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
   localparam logic [DW-1:0] CD_LAST  = DW'(CD_DEBOUNCE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        wr_sync_q, wr_sync_d, rd_sync_q, rd_sync_d, cd_sync_q, cd_sync_d;
   logic [7:0]        clkdiv_q, clkdiv_d, div_lat_q, div_lat_d, div_cnt_q, div_cnt_d;
   logic [NUM_CS-1:0] slave_sel_q, slave_sel_d;
   logic [3:0]        mode_q, mode_d, edge_cnt_q, edge_cnt_d;
   logic [2:0]        intreq_q, intreq_d, intena_q, intena_d, int_set, int_clr;
   logic              card_det_q, card_det_d, rx_ovf_q, rx_ovf_d, busy_q, busy_d;
   logic              sclk_q, sclk_d, mosi_q, mosi_d;
   logic [DW-1:0]     cd_cnt_q, cd_cnt_d;
   logic [7:0]        tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic [15:0]       data_out_q, data_out_d, rd_val;
   logic [CW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [CW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [CW-1:0]     tx_count, rx_count;
   logic [7:0]        tx_mem [FIFO_DEPTH];
   logic [7:0]        rx_mem [FIFO_DEPTH];
   logic [7:0]        tx_head, rx_head;
   logic              tx_push, tx_pop, rx_push, rx_pop;
   logic              tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
   logic              tx_empty, tx_full, rx_empty, rx_full;
   logic              busy, wr_stb, rd_stb, lsb, cpha, cpol, sample, cd_now;
   logic [3:0]        reg_addr;
   logic              unused_ok;
`ifdef SPI_CRC16_EN
   logic [15:0]       crc_q, crc_d;
   logic              crc_fb;
`endif

   assign tx_count = tx_wptr_q - tx_rptr_q;
   assign rx_count = rx_wptr_q - rx_rptr_q;
   assign tx_empty = (tx_count == '0);
   assign rx_empty = (rx_count == '0);
   assign tx_full  = (tx_count == FULL_LVL);
   assign rx_full  = (rx_count == FULL_LVL);
   assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];
   assign rx_head  = rx_mem[rx_rptr_q[AW-1:0]];
   assign busy     = (state_q != ST_IDLE) || !tx_empty;
   assign lsb      = mode_q[2];
   assign cpha     = mode_q[1];
   assign cpol     = mode_q[0];
   assign wr_stb   = wr_sync_q[1] & ~wr_sync_q[2];
   assign rd_stb   = rd_sync_q[1] & ~rd_sync_q[2];
   assign reg_addr = ADDR[4:1];
   assign cd_now   = ~cd_sync_q[2];

   assign dtack_n  = ~access;
   assign data_oe  = access & ~ds_n & RW;
   assign data_out = data_out_q;
   assign INT2_n   = ~|(intreq_q & intena_q);
   assign SS_n     = ~slave_sel_q;
   assign SCLK     = sclk_q;
   assign MOSI     = mosi_q;
   assign unused_ok = ^{ADDR[23:5], data_in[15:8]};

   always_comb begin
      rd_val = 16'h0000;
      case (reg_addr)
         4'd0:    rd_val = {8'h00, clkdiv_q};
         4'd1:    rd_val = 16'(slave_sel_q);
         4'd2:    rd_val = {15'd0, card_det_q};
         4'd3:    rd_val = {12'd0, rx_ovf_q, rx_empty, tx_full, busy};
         4'd4:    rd_val = rx_empty ? 16'h00FF : {8'h00, rx_head};
         4'd5:    rd_val = {13'd0, intreq_q};
         4'd6:    rd_val = {13'd0, intena_q};
         4'd7:    rd_val = {13'd0, intreq_q & intena_q};
         4'd8:    rd_val = {12'd0, mode_q};
         4'd9:    rd_val = {8'(rx_count), 8'(tx_count)};
`ifdef SPI_CRC16_EN
         4'd10:   rd_val = crc_q;
`endif
         default: rd_val = 16'h0000;
      endcase
   end

   // Bus decode, shift engine, debounce and FIFO bookkeeping all resolve here into *_d.
   always_comb begin
      state_d     = state_q;
      wr_sync_d   = {wr_sync_q[1:0], access & ~ds_n & ~RW};
      rd_sync_d   = {rd_sync_q[1:0], access & ~ds_n & RW};
      cd_sync_d   = {cd_sync_q[1:0], CD_n};
      clkdiv_d    = clkdiv_q;
      div_lat_d   = div_lat_q;
      div_cnt_d   = div_cnt_q;
      slave_sel_d = slave_sel_q;
      mode_d      = mode_q;
      edge_cnt_d  = edge_cnt_q;
      intena_d    = intena_q;
      card_det_d  = card_det_q;
      rx_ovf_d    = rx_ovf_q;
      busy_d      = busy;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      cd_cnt_d    = cd_cnt_q;
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      data_out_d  = data_out_q;
      int_set     = 3'b000;
      int_clr     = 3'b000;
      tx_push     = 1'b0;
      tx_pop      = 1'b0;
      rx_push     = 1'b0;
      rx_pop      = 1'b0;
      sample      = ~edge_cnt_q[0] ^ cpha;
`ifdef SPI_CRC16_EN
      crc_d       = crc_q;
      crc_fb      = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            sclk_d = cpol;
            mosi_d = 1'b1;
            if (!tx_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            mosi_d     = lsb ? tx_head[0] : tx_head[7];
            sclk_d     = cpol;
            div_cnt_d  = 8'h00;
            edge_cnt_d = 4'd0;
            div_lat_d  = clkdiv_q;
            state_d    = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (div_cnt_q == div_lat_q) begin
               div_cnt_d  = 8'h00;
               sclk_d     = ~sclk_q;
               edge_cnt_d = edge_cnt_q + 4'd1;
               if (sample) begin
                  rx_sh_d = lsb ? {MISO, rx_sh_q[7:1]} : {rx_sh_q[6:0], MISO};
`ifdef SPI_CRC16_EN
                  crc_fb = crc_q[15] ^ (mode_q[3] ? mosi_q : MISO);
                  crc_d  = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
               end else if (edge_cnt_q != 4'd15) begin
                  // CPHA=1 drives the current bit on the leading edge; CPHA=0 moves to the next bit.
                  mosi_d  = cpha ? (lsb ? tx_sh_q[0] : tx_sh_q[7])
                                 : (lsb ? tx_sh_q[1] : tx_sh_q[6]);
                  tx_sh_d = lsb ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
               end
               if (edge_cnt_q == 4'd15) begin
                  rx_push = 1'b1;
                  if (tx_empty) begin
                     state_d = ST_IDLE;
                     mosi_d  = 1'b1;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'h01;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (cd_now == card_det_q) begin
         cd_cnt_d = '0;
      end else if (cd_cnt_q == CD_LAST) begin
         cd_cnt_d   = '0;
         card_det_d = cd_now;
         int_set[0] = 1'b1;
      end else begin
         cd_cnt_d = cd_cnt_q + 1'b1;
      end

      if (wr_stb) begin
         case (reg_addr)
            4'd0: clkdiv_d = data_in[7:0];
            4'd1: if (!busy) slave_sel_d = data_in[NUM_CS-1:0];
            4'd4: tx_push = 1'b1;
            4'd5: int_clr = data_in[2:0];
            4'd6: intena_d = data_in[2:0];
`ifdef SPI_CRC16_EN
            4'd8: if (!busy) mode_d = data_in[3:0];
            4'd10: crc_d = 16'h0000;
`else
            4'd8: if (!busy) mode_d = {1'b0, data_in[2:0]};
`endif
            default: ;
         endcase
      end

      if (rd_stb) begin
         data_out_d = rd_val;
         if (reg_addr == 4'd4) rx_pop = 1'b1;
      end

      tx_push_ok = tx_push & ~tx_full;
      tx_pop_ok  = tx_pop & ~tx_empty;
      rx_push_ok = rx_push & ~rx_full;
      rx_pop_ok  = rx_pop & ~rx_empty;
      tx_wptr_d  = tx_wptr_q + CW'(tx_push_ok);
      tx_rptr_d  = tx_rptr_q + CW'(tx_pop_ok);
      rx_wptr_d  = rx_wptr_q + CW'(rx_push_ok);
      rx_rptr_d  = rx_rptr_q + CW'(rx_pop_ok);

      if (int_clr[2]) rx_ovf_d = 1'b0;
      if (rx_push & rx_full) begin
         rx_ovf_d   = 1'b1;
         int_set[2] = 1'b1;
      end
      if (busy_q & ~busy) int_set[1] = 1'b1;
      // A new event in the same cycle as a W1C clear keeps its bit set.
      intreq_d = (intreq_q & ~int_clr) | int_set;
   end

   always_ff @(posedge C100M or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         wr_sync_q   <= 3'b000;
         rd_sync_q   <= 3'b000;
         cd_sync_q   <= 3'b111;
         clkdiv_q    <= 8'hFF;
         div_lat_q   <= 8'hFF;
         div_cnt_q   <= 8'h00;
         slave_sel_q <= '0;
         mode_q      <= 4'h0;
         edge_cnt_q  <= 4'd0;
         intreq_q    <= 3'b000;
         intena_q    <= 3'b000;
         card_det_q  <= 1'b0;
         rx_ovf_q    <= 1'b0;
         busy_q      <= 1'b0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b1;
         cd_cnt_q    <= '0;
         tx_sh_q     <= 8'h00;
         rx_sh_q     <= 8'h00;
         data_out_q  <= 16'h0000;
         tx_wptr_q   <= '0;
         tx_rptr_q   <= '0;
         rx_wptr_q   <= '0;
         rx_rptr_q   <= '0;
`ifdef SPI_CRC16_EN
         crc_q       <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         wr_sync_q   <= wr_sync_d;
         rd_sync_q   <= rd_sync_d;
         cd_sync_q   <= cd_sync_d;
         clkdiv_q    <= clkdiv_d;
         div_lat_q   <= div_lat_d;
         div_cnt_q   <= div_cnt_d;
         slave_sel_q <= slave_sel_d;
         mode_q      <= mode_d;
         edge_cnt_q  <= edge_cnt_d;
         intreq_q    <= intreq_d;
         intena_q    <= intena_d;
         card_det_q  <= card_det_d;
         rx_ovf_q    <= rx_ovf_d;
         busy_q      <= busy_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         cd_cnt_q    <= cd_cnt_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         data_out_q  <= data_out_d;
         tx_wptr_q   <= tx_wptr_d;
         tx_rptr_q   <= tx_rptr_d;
         rx_wptr_q   <= rx_wptr_d;
         rx_rptr_q   <= rx_rptr_d;
`ifdef SPI_CRC16_EN
         crc_q       <= crc_d;
`endif
      end
   end

   always_ff @(posedge C100M) begin
      if (tx_push_ok) tx_mem[tx_wptr_q[AW-1:0]] <= data_in[7:0];
      if (rx_push_ok) rx_mem[rx_wptr_q[AW-1:0]] <= rx_sh_d;
   end
endmodule

// File: tb/tb_spi_burst_host.sv
// Directed bench for spi_burst_host: register vector table plus hand-written transfer,
// FIFO boundary, interrupt, debounce and mid-byte reset sequences. MISO is looped back from MOSI.
module tb_spi_burst_host;
   logic        clk = 1'b0;
   logic        RESET;
   logic [23:1] ADDR;
   logic        access, RW, ds_n, dtack_n, data_oe, INT2_n, SCLK, MOSI, MISO, CD_n;
   logic [15:0] data_in, data_out;
   logic [1:0]  SS_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   assign MISO = MOSI;

   spi_burst_host #(.NUM_CS(2), .FIFO_DEPTH(16), .CD_DEBOUNCE(64)) dut (
      .C100M(clk), .RESET(RESET), .ADDR(ADDR), .access(access), .RW(RW), .ds_n(ds_n),
      .dtack_n(dtack_n), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
      .INT2_n(INT2_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CD_n(CD_n)
   );

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [15];

   // SCLK monitors: rising-edge bit capture for mode 0, and any-edge gap tracking for bursts.
   bit        mon_en = 1'b0;
   int        mon_cnt = 0, mon_bad_period = 0, mon_bad_ss = 0;
   logic [7:0] mon_bits = 8'h00;
   time       last_rise = 0;
   bit        gap_en = 1'b0;
   int        gap_edges = 0;
   time       last_edge = 0, max_gap = 0;
   bit        int_low_seen = 1'b0;

   always @(posedge SCLK) if (mon_en) begin
      if (mon_cnt > 0 && ($time - last_rise) != 20) mon_bad_period++;
      if (SS_n !== 2'b10) mon_bad_ss++;
      last_rise = $time;
      mon_bits  = {mon_bits[6:0], MOSI};
      mon_cnt++;
   end

   always @(SCLK) if (gap_en) begin
      if (gap_edges > 0 && ($time - last_edge) > max_gap) max_gap = $time - last_edge;
      last_edge = $time;
      gap_edges++;
   end

   always @(negedge INT2_n) int_low_seen = 1'b1;

   initial begin
      repeat (60000) @(posedge clk);
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%04h required 0x%04h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      ADDR = {19'd0, a}; data_in = d; RW = 1'b0; access = 1'b1; ds_n = 1'b0;
      repeat (5) @(negedge clk);
      access = 1'b0; ds_n = 1'b1; RW = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
      @(negedge clk);
      ADDR = {19'd0, a}; RW = 1'b1; access = 1'b1; ds_n = 1'b0;
      repeat (5) @(negedge clk);
      d = data_out;
      access = 1'b0; ds_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [15:0] exp);
      logic [15:0] v;
      bus_read(a, v);
      checkOutput(name, v, exp);
   endtask

   task automatic applyStimulus(input vec_t v, output logic [15:0] got);
      if (v.wr) bus_write(v.addr, v.wdata);
      bus_read(v.addr, got);
   endtask

   task automatic wait_idle(input int max_reads);
      logic [15:0] s;
      int n = 0;
      do begin
         bus_read(4'd3, s);
         n++;
      end while (s[0] && n < max_reads);
      if (s[0]) checkOutput("idle_timeout", {15'd0, s[0]}, 16'h0000);
   endtask

   initial begin
      logic [15:0] got;
      int i;
      RESET = 1'b1; access = 1'b0; ds_n = 1'b1; RW = 1'b1; ADDR = '0; data_in = 16'h0000; CD_n = 1'b1;
      repeat (3) @(negedge clk);
      RESET = 1'b0;
      @(negedge clk);
      checkOutput("rst_data_out", data_out, 16'h0000);
      checkOutput("rst_int2_n", {15'd0, INT2_n}, 16'h0001);
      checkOutput("rst_ss_n", {14'd0, SS_n}, 16'h0003);
      checkOutput("rst_sclk", {15'd0, SCLK}, 16'h0000);
      checkOutput("rst_mosi", {15'd0, MOSI}, 16'h0001);
      checkOutput("rst_dtack_n", {15'd0, dtack_n}, 16'h0001);
      checkOutput("rst_data_oe", {15'd0, data_oe}, 16'h0000);

      vecs[0]  = '{1'b0, 4'd0,  16'h0000, 16'h00FF};
      vecs[1]  = '{1'b0, 4'd8,  16'h0000, 16'h0000};
      vecs[2]  = '{1'b0, 4'd3,  16'h0000, 16'h0004};
      vecs[3]  = '{1'b0, 4'd9,  16'h0000, 16'h0000};
      vecs[4]  = '{1'b0, 4'd5,  16'h0000, 16'h0000};
      vecs[5]  = '{1'b0, 4'd6,  16'h0000, 16'h0000};
      vecs[6]  = '{1'b0, 4'd2,  16'h0000, 16'h0000};
      vecs[7]  = '{1'b1, 4'd0,  16'h1234, 16'h0034};
`ifdef SPI_CRC16_EN
      vecs[8]  = '{1'b1, 4'd8,  16'h000F, 16'h000F};
`else
      vecs[8]  = '{1'b1, 4'd8,  16'h000F, 16'h0007};
`endif
      vecs[9]  = '{1'b1, 4'd1,  16'h00FF, 16'h0003};
      vecs[10] = '{1'b1, 4'd6,  16'hFFFF, 16'h0007};
      vecs[11] = '{1'b1, 4'd12, 16'hBEEF, 16'h0000};
      vecs[12] = '{1'b0, 4'd7,  16'h0000, 16'h0000};
      vecs[13] = '{1'b0, 4'd4,  16'h0000, 16'h00FF};
      vecs[14] = '{1'b1, 4'd10, 16'h5555, 16'h0000};
      for (int k = 0; k < 15; k++) begin
         applyStimulus(vecs[k], got);
         checkOutput($sformatf("vec%0d_addr%0d", k, vecs[k].addr), got, vecs[k].exp);
      end

      @(negedge clk);
      ADDR = {19'd0, 4'd0}; RW = 1'b1; access = 1'b1; ds_n = 1'b0;
      #1;
      checkOutput("bus_data_oe", {15'd0, data_oe}, 16'h0001);
      checkOutput("bus_dtack_n", {15'd0, dtack_n}, 16'h0000);
      repeat (5) @(negedge clk);
      access = 1'b0; ds_n = 1'b1;
      repeat (4) @(negedge clk);

      bus_write(4'd8, 16'h0000);
      bus_write(4'd6, 16'h0000);
      bus_write(4'd0, 16'h0000);
      bus_write(4'd1, 16'h0001);
      bus_write(4'd5, 16'h0007);

      // Mode 0, CLKDIV 0: one byte 0xA5, MSB first at 50 MHz.
      int_low_seen = 1'b0;
      mon_cnt = 0; mon_bad_period = 0; mon_bad_ss = 0; mon_bits = 8'h00;
      mon_en = 1'b1;
      bus_write(4'd4, 16'h00A5);
      wait_idle(50);
      mon_en = 1'b0;
      checkOutput("a5_pulses", 16'(mon_cnt), 16'd8);
      checkOutput("a5_mosi_bits", {8'h00, mon_bits}, 16'h00A5);
      checkOutput("a5_period_errs", 16'(mon_bad_period), 16'd0);
      checkOutput("a5_ss_errs", 16'(mon_bad_ss), 16'd0);
      checkOutput("a5_int_low_seen", {15'd0, int_low_seen}, 16'h0000);
      read_check("a5_rx", 4'd4, 16'h00A5);

      // Mode 3, LSB first: three-byte burst, loopback data and inter-byte gap.
      bus_write(4'd8, 16'h0007);
      gap_edges = 0; max_gap = 0; last_edge = 0;
      gap_en = 1'b1;
      bus_write(4'd4, 16'h0001);
      bus_write(4'd4, 16'h0080);
      bus_write(4'd4, 16'h003C);
      wait_idle(50);
      gap_en = 1'b0;
      checkOutput("burst_edges", 16'(gap_edges), 16'd48);
      checkOutput("burst_gap_ok", {15'd0, (max_gap <= 20)}, 16'h0001);
      read_check("burst_rx0", 4'd4, 16'h0001);
      read_check("burst_rx1", 4'd4, 16'h0080);
      read_check("burst_rx2", 4'd4, 16'h003C);
      bus_write(4'd8, 16'h0000);

      // RX overflow: 17 bytes with no reads.
      bus_write(4'd5, 16'h0007);
      for (i = 0; i < 17; i++) bus_write(4'd4, 16'(i));
      wait_idle(100);
      read_check("ovf_status", 4'd3, 16'h0008);
      read_check("ovf_levels", 4'd9, 16'h1000);
      read_check("ovf_intreq", 4'd5, 16'h0006);
      checkOutput("ovf_int2_n_masked", {15'd0, INT2_n}, 16'h0001);
      bus_write(4'd6, 16'h0004);
      checkOutput("ovf_int2_n_enabled", {15'd0, INT2_n}, 16'h0000);
      bus_write(4'd5, 16'h0004);
      checkOutput("ovf_int2_n_cleared", {15'd0, INT2_n}, 16'h0001);
      read_check("ovf_status_cleared", 4'd3, 16'h0000);
      for (i = 0; i < 16; i++) read_check($sformatf("ovf_rx%0d", i), 4'd4, 16'(i));
      read_check("ovf_rx_empty", 4'd4, 16'h00FF);
      bus_write(4'd6, 16'h0000);

      // TX fill with a slow clock: first byte goes to the shifter, next 16 fill the FIFO.
      bus_write(4'd0, 16'h00FF);
      for (i = 0; i < 17; i++) bus_write(4'd4, 16'h00C0 + 16'(i));
      read_check("fill_status", 4'd3, 16'h0007);
      read_check("fill_levels", 4'd9, 16'h0010);
      bus_write(4'd4, 16'h00EE);
      read_check("fill_levels_drop", 4'd9, 16'h0010);
      bus_write(4'd8, 16'h0003);
      read_check("busy_mode_ignored", 4'd8, 16'h0000);
      bus_write(4'd1, 16'h0002);
      read_check("busy_ss_ignored", 4'd1, 16'h0001);

      // Reset in the middle of a byte.
      i = 0;
      while (SCLK !== 1'b1 && i < 2000) begin
         @(negedge clk);
         i++;
      end
      checkOutput("midbyte_sclk_high", {15'd0, SCLK}, 16'h0001);
      RESET = 1'b1;
      #1;
      checkOutput("midbyte_rst_sclk", {15'd0, SCLK}, 16'h0000);
      checkOutput("midbyte_rst_ss_n", {14'd0, SS_n}, 16'h0003);
      @(negedge clk);
      RESET = 1'b0;
      read_check("midbyte_status", 4'd3, 16'h0004);
      read_check("midbyte_levels", 4'd9, 16'h0000);
      read_check("midbyte_clkdiv", 4'd0, 16'h00FF);

      // Card detect: short glitch, then stable low past the debounce window.
      CD_n = 1'b0;
      repeat (20) @(negedge clk);
      CD_n = 1'b1;
      repeat (10) @(negedge clk);
      CD_n = 1'b0;
      repeat (30) @(negedge clk);
      read_check("cd_early", 4'd2, 16'h0000);
      read_check("cd_early_intreq", 4'd5, 16'h0000);
      repeat (80) @(negedge clk);
      read_check("cd_settled", 4'd2, 16'h0001);
      read_check("cd_intreq", 4'd5, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
